// File: rtl/ysyx_23060077_riscv_wbu.sv
// Write-back / commit stage for a single-issue, non-pipelined RISC-V core.
// Latches one execute result, optionally issues a data-memory read, then
// retires the instruction in a one-cycle COMMIT state. During COMMIT it
// drives the register-file write and the architectural next PC.
// Optional feature: define YSYX_23060077_WBU_MISALIGN_CHK_EN to trap
// misaligned LH/LHU/LW. A trapped load skips memory and raises exc_valid.
module ysyx_23060077_riscv_wbu #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    REG_ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_PC       = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     pc,
  input  logic [DATA_WIDTH-1:0]     src1,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic [DATA_WIDTH-1:0]     exu_result,
  input  logic                      zero_flag,
  input  logic                      branch,
  input  logic                      is_jal,
  input  logic                      is_jalr,
  input  logic                      mem_read,
  input  logic [2:0]                funct3,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      rd_wen,
  output logic                      mem_req,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic [DATA_WIDTH-1:0]     pc_out,
  output logic                      commit,
  output logic                      exc_valid
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEM_REQ  = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_COMMIT   = 2'd3;

  logic [1:0]                r_state;
  logic [DATA_WIDTH-1:0]     r_pc;
  logic [DATA_WIDTH-1:0]     r_ipc;
  logic [DATA_WIDTH-1:0]     r_src1;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [DATA_WIDTH-1:0]     r_res;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_zero;
  logic                      r_branch;
  logic                      r_jal;
  logic                      r_jalr;
  logic                      r_mread;
  logic [2:0]                r_f3;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_rdwen;
  logic                      r_exc;

  logic                      w_exc;
  logic                      w_in_commit;
  logic [DATA_WIDTH-1:0]     w_npc;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic [DATA_WIDTH-1:0]     w_ldata;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;

`ifdef YSYX_23060077_WBU_MISALIGN_CHK_EN
  // A misaligned half or word load is trapped at acceptance, so it never reaches memory.
  logic w_misalign;
  always_comb begin
    w_misalign = 1'b0;
    case (funct3)
      3'b001, 3'b101: w_misalign = exu_result[0];
      3'b010:         w_misalign = |exu_result[1:0];
      default:        w_misalign = 1'b0;
    endcase
  end
  assign w_exc = mem_read & w_misalign;
`else
  assign w_exc = 1'b0;
`endif

  // Main FSM, input latch and architectural PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_ipc    <= '0;
      r_src1   <= '0;
      r_imm    <= '0;
      r_res    <= '0;
      r_rdata  <= '0;
      r_zero   <= 1'b0;
      r_branch <= 1'b0;
      r_jal    <= 1'b0;
      r_jalr   <= 1'b0;
      r_mread  <= 1'b0;
      r_f3     <= '0;
      r_rd     <= '0;
      r_rdwen  <= 1'b0;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_ipc    <= pc;
          r_src1   <= src1;
          r_imm    <= imm;
          r_res    <= exu_result;
          r_zero   <= zero_flag;
          r_branch <= branch;
          r_jal    <= is_jal;
          r_jalr   <= is_jalr;
          r_mread  <= mem_read;
          r_f3     <= funct3;
          r_rd     <= rd;
          r_rdwen  <= rd_wen;
          r_exc    <= w_exc;
          r_state  <= (mem_read && !w_exc) ? S_MEM_REQ : S_COMMIT;
        end
        S_MEM_REQ: r_state <= S_MEM_WAIT;
        S_MEM_WAIT: if (mem_rvalid) begin
          r_rdata <= mem_rdata;
          r_state <= S_COMMIT;
        end
        default: begin
          if (!r_exc) r_pc <= w_npc;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Next PC: jalr, then jal, then a taken branch, else fall through.
  always_comb begin
    w_npc = r_ipc + DATA_WIDTH'(4);
    if (r_jalr)                 w_npc = (r_src1 + r_imm) & ~DATA_WIDTH'(1);
    else if (r_jal)             w_npc = r_ipc + r_imm;
    else if (r_branch && !r_zero) w_npc = r_ipc + r_imm;
  end

  assign w_byte = r_rdata[{r_res[1:0], 3'b000} +: 8];
  assign w_half = r_rdata[{r_res[1], 4'b0000} +: 16];

  // Load lane select and sign or zero extension.
  always_comb begin
    w_ldata = r_rdata;
    case (r_f3)
      3'b000:  w_ldata = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_ldata = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_ldata = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_ldata = r_rdata;
    endcase
  end

  assign w_wdata     = r_mread ? w_ldata : r_res;
  assign w_in_commit = (r_state == S_COMMIT);

  assign in_ready  = (r_state == S_IDLE);
  assign mem_req   = (r_state == S_MEM_REQ);
  assign mem_addr  = mem_req ? {r_res[DATA_WIDTH-1:2], 2'b00} : '0;
  assign commit    = w_in_commit && !r_exc;
  assign exc_valid = w_in_commit && r_exc;
  assign reg_wen   = commit && r_rdwen && !r_branch && (r_rd != '0);
  assign reg_waddr = w_in_commit ? r_rd : '0;
  assign reg_wdata = w_in_commit ? w_wdata : '0;
  assign pc_out    = commit ? w_npc : r_pc;

endmodule

// File: tb/tb_ysyx_23060077_riscv_wbu.sv
// Randomized self-checking bench for the write-back stage. Directed cases come
// first, then random traffic. A transaction-level model predicts each outcome.
module tb_ysyx_23060077_riscv_wbu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc = '0, src1 = '0, imm = '0, exu_result = '0;
  logic        zero_flag = 1'b0, branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
  logic        mem_read = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        rd_wen = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [31:0] pc_out;
  logic        commit;
  logic        exc_valid;

  ysyx_23060077_riscv_wbu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .src1(src1), .imm(imm), .exu_result(exu_result),
    .zero_flag(zero_flag), .branch(branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .mem_read(mem_read), .funct3(funct3), .rd(rd), .rd_wen(rd_wen),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .pc_out(pc_out), .commit(commit), .exc_valid(exc_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, src1, imm, res;
    logic        zero, br, jal, jalr, mrd;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wen;
    int          waits;
    logic [31:0] rdata;
  } txn_t;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] m_pc = RST_PC;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: next PC from the instruction's control-flow rules.
  function automatic logic [31:0] ref_npc(input txn_t t);
    if (t.jalr) return (t.src1 + t.imm) & 32'hFFFF_FFFE;
    if (t.jal) return t.pc + t.imm;
    if (t.br && !t.zero) return t.pc + t.imm;
    return t.pc + 32'd4;
  endfunction

  // Reference: load result by shifting out the addressed byte or half.
  function automatic logic [31:0] ref_load(input txn_t t);
    logic [31:0] b, h;
    b = (t.rdata >> (8 * (t.res % 4))) & 32'hFF;
    h = (t.rdata >> (16 * ((t.res / 2) % 2))) & 32'hFFFF;
    case (t.f3)
      3'd0: return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1: return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return t.rdata;
    endcase
  endfunction

  function automatic logic ref_exc(input txn_t t);
`ifdef YSYX_23060077_WBU_MISALIGN_CHK_EN
    if (!t.mrd) return 1'b0;
    if ((t.f3 == 3'd1 || t.f3 == 3'd5) && (t.res % 2 != 0)) return 1'b1;
    if (t.f3 == 3'd2 && (t.res % 4 != 0)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input txn_t t);
    pc = t.pc; src1 = t.src1; imm = t.imm; exu_result = t.res;
    zero_flag = t.zero; branch = t.br; is_jal = t.jal; is_jalr = t.jalr;
    mem_read = t.mrd; funct3 = t.f3; rd = t.rd; rd_wen = t.wen;
  endtask

  // Scramble the inputs after acceptance, so a stage that fails to latch them is caught.
  task automatic scramble();
    pc = $urandom; src1 = $urandom; imm = $urandom; exu_result = $urandom;
    zero_flag = 1'($urandom); branch = 1'($urandom); is_jal = 1'($urandom);
    is_jalr = 1'($urandom); mem_read = 1'($urandom); funct3 = 3'($urandom);
    rd = 5'($urandom); rd_wen = 1'($urandom);
  endtask

  // One full transaction, starting and ending at a negedge.
  task automatic run(input txn_t t);
    logic        exc;
    logic [31:0] npc;
    logic        ewen;
    exc  = ref_exc(t);
    npc  = ref_npc(t);
    ewen = !exc && t.wen && !t.br && (t.rd != 0);
    chk("idle_ready", {31'b0, in_ready}, 32'd1);
    drive(t);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    scramble();
    if (t.mrd && !exc) begin
      chk("mem_req", {31'b0, mem_req}, 32'd1);
      chk("mem_addr", mem_addr, t.res & 32'hFFFF_FFFC);
      chk("busy_ready", {31'b0, in_ready}, 32'd0);
      step();
      chk("req_once", {31'b0, mem_req}, 32'd0);
      for (int i = 0; i < t.waits; i++) begin
        mem_rdata = $urandom;
        chk("wait_commit", {31'b0, commit}, 32'd0);
        step();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = t.rdata;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end else begin
      chk("no_req", {31'b0, mem_req}, 32'd0);
    end
    chk("commit", {31'b0, commit}, {31'b0, !exc});
    chk("exc_valid", {31'b0, exc_valid}, {31'b0, exc});
    chk("reg_wen", {31'b0, reg_wen}, {31'b0, ewen});
    if (ewen) begin
      chk("reg_waddr", {27'b0, reg_waddr}, {27'b0, t.rd});
      chk("reg_wdata", reg_wdata, t.mrd ? ref_load(t) : t.res);
    end
    if (!exc) m_pc = npc;
    chk("pc_commit", pc_out, m_pc);
    step();
    chk("post_commit", {31'b0, commit}, 32'd0);
    chk("pc_hold", pc_out, m_pc);
  endtask

  function automatic txn_t blank();
    txn_t t;
    t.pc = 0; t.src1 = 0; t.imm = 0; t.res = 0; t.zero = 0; t.br = 0;
    t.jal = 0; t.jalr = 0; t.mrd = 0; t.f3 = 0; t.rd = 0; t.wen = 0;
    t.waits = 0; t.rdata = 0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   k;
    t = blank();
    k = int'($urandom_range(0, 4));
    t.pc = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) t.pc = 32'hFFFF_FFFC;
    t.src1 = $urandom; t.imm = $urandom; t.res = $urandom;
    t.rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    t.wen = 1'($urandom);
    t.waits = int'($urandom_range(0, 3));
    t.rdata = $urandom;
    case (k)
      1: begin t.br = 1; t.res = 32'($urandom_range(0, 1)); end
      2: begin t.jal = 1; t.res = t.pc + 4; end
      3: begin t.jalr = 1; t.res = t.pc + 4; end
      4: begin t.mrd = 1; t.f3 = 3'($urandom); end
      default: ;
    endcase
    t.zero = (t.res == 0);
    return t;
  endfunction

  initial begin
    txn_t t;
    // Reset state
    #12;
    chk("rst_pc", pc_out, RST_PC);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_outs", {26'b0, mem_req, reg_wen, commit, exc_valid, 2'b0}, 32'd0);
    chk("rst_data", reg_wdata | mem_addr | {27'b0, reg_waddr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Simple ALU op
    t = blank(); t.pc = 32'h8000_0000; t.res = 7; t.rd = 5; t.wen = 1;
    run(t);
    // Taken and not-taken branch
    t = blank(); t.pc = 32'h8000_0010; t.imm = 32'hFFFF_FFF8; t.br = 1;
    t.res = 1; t.rd = 3; t.wen = 1;
    run(t);
    chk("br_taken_pc", pc_out, 32'h8000_0008);
    t.res = 0; t.zero = 1;
    run(t);
    chk("br_nt_pc", pc_out, 32'h8000_0014);
    // jalr clears bit 0
    t = blank(); t.pc = 32'h8000_0020; t.src1 = 32'h8000_0101; t.imm = 4;
    t.jalr = 1; t.res = 32'h8000_0024; t.rd = 1; t.wen = 1;
    run(t);
    chk("jalr_pc", pc_out, 32'h8000_0104);
    // LB / LBU at byte 3 after two wait cycles
    t = blank(); t.pc = 32'h8000_0030; t.mrd = 1; t.f3 = 3'd0;
    t.res = 32'h8000_0003; t.rdata = 32'h80A5_5A11; t.waits = 2; t.rd = 9; t.wen = 1;
    run(t);
    t.f3 = 3'd4;
    run(t);
    // rvalid on the first wait cycle
    t.f3 = 3'd1; t.res = 32'h8000_0002; t.waits = 0;
    run(t);
    // x0 is never written
    t = blank(); t.pc = 32'h8000_0040; t.res = 32'h1234; t.rd = 0; t.wen = 1;
    run(t);
`ifdef YSYX_23060077_WBU_MISALIGN_CHK_EN
    t = blank(); t.pc = 32'h8000_0050; t.mrd = 1; t.f3 = 3'd2;
    t.res = 32'h8000_0002; t.rd = 4; t.wen = 1;
    run(t);
`endif

    // Reset during MEM_WAIT; a late rvalid must be ignored.
    t = blank(); t.pc = 32'h8000_0060; t.mrd = 1; t.f3 = 3'd2;
    t.res = 32'h8000_0100; t.rd = 6; t.wen = 1;
    drive(t);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc_out, RST_PC);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RST_PC;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      mem_rvalid = 1'b0;
      chk("late_commit", {31'b0, commit}, 32'd0);
      chk("late_wen", {31'b0, reg_wen}, 32'd0);
      chk("late_ready", {31'b0, in_ready}, 32'd1);
      chk("late_pc", pc_out, RST_PC);
    end

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      t = rand_txn();
      run(t);
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_riscv_wbu.md
Name: ysyx_23060077_riscv_wbu

Overview:
- Write-back/commit stage; consumes the execute unit's result, zero_flag and decoded control.
- Issues load reads to data memory and sign/zero-extends load data.
- Computes the architectural next PC: branch, jal, jalr or sequential.
- Commits one instruction at a time to the register file and PC register; single-issue, non-pipelined.

Parameters:
- DATA_WIDTH, 32, datapath width.
- REG_ADDR_WIDTH, 5, register index width.
- RESET_PC, 32'h8000_0000, PC value after reset.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  execute result valid.
- in_ready  output  1  stage can accept; high only in IDLE.
- pc  input  DATA_WIDTH  PC of the instruction.
- src1  input  DATA_WIDTH  rs1 value, used for jalr.
- imm  input  DATA_WIDTH  immediate.
- exu_result  input  DATA_WIDTH  ALU result, load address, or branch-taken bit.
- zero_flag  input  1  high when exu_result==0.
- branch  input  1  conditional branch.
- is_jal  input  1  jal.
- is_jalr  input  1  jalr.
- mem_read  input  1  load.
- funct3  input  3  load width/sign select.
- rd  input  REG_ADDR_WIDTH  destination register.
- rd_wen  input  1  instruction writes rd.
- mem_req  output  1  one-cycle load request pulse.
- mem_addr  output  DATA_WIDTH  word-aligned load address.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  DATA_WIDTH  read data word.
- reg_wen  output  1  register-file write strobe; one cycle.
- reg_waddr  output  REG_ADDR_WIDTH  write index.
- reg_wdata  output  DATA_WIDTH  write data.
- pc_out  output  DATA_WIDTH  architectural PC; holds the next fetch address.
- commit  output  1  one-cycle retire pulse.
- exc_valid  output  1  misaligned-load exception pulse; only meaningful with the optional feature.

Behaviour:
- Reset: state IDLE, pc_out=RESET_PC, all other outputs 0. Reset mid-load aborts to IDLE; a late mem_rvalid after reset is ignored.
- FSM states: IDLE, MEM_REQ, MEM_WAIT, COMMIT.
- IDLE, in_valid=1: latch all inputs. Go to MEM_REQ if mem_read, else COMMIT. in_valid=0: stay.
- MEM_REQ: mem_req=1 for exactly one cycle; mem_addr={exu_result[31:2],2'b00}; go to MEM_WAIT.
- MEM_WAIT: wait indefinitely. On mem_rvalid, latch mem_rdata and go to COMMIT. rvalid in the same cycle as entry is legal.
- COMMIT (one cycle): commit=1; pc_out updates; reg_wen=latched rd_wen && rd!=0; return to IDLE.
- Latency: non-load commits the cycle after acceptance. A load commits the cycle after mem_rvalid; minimum 3 cycles after acceptance.
- Next PC, in priority order:
  - is_jalr: (src1+imm) & ~1.
  - is_jal: pc+imm.
  - branch && !zero_flag (taken): pc+imm.
  - otherwise pc+4.
  - All arithmetic is modulo 2^DATA_WIDTH (wraps).
- Write data:
  - Load: lane = addr[1:0].
    - 000 LB: sign-extend byte.
    - 001 LH: sign-extend half at addr[1].
    - 010 LW: full word.
    - 100 LBU: zero-extend byte.
    - 101 LHU: zero-extend half.
    - Other funct3 values: full word.
  - Non-load: exu_result. For jal/jalr this is the link value pc+4 supplied by EXU.
- Branch: reg_wen=0 regardless of rd_wen.
- Misaligned load without the feature: LH at addr[0]=1 uses half at addr[1]; LW ignores addr[1:0].

Optional Feature:
- Macro: YSYX_23060077_WBU_MISALIGN_CHK_EN.
- Defined: a load with (LH/LHU and addr[0]=1) or (LW and addr[1:0]!=0) skips MEM_REQ/MEM_WAIT and goes straight to COMMIT. In COMMIT: exc_valid=1, reg_wen=0, commit=0, pc_out unchanged.
- Undefined: exc_valid tied 0; misaligned loads behave as above.

Test Plan:
- Reset release -> pc_out=32'h8000_0000, in_ready=1, outputs 0. Add pc=0x8000_0000, exu_result=7, rd=5 -> next cycle commit=1, reg_waddr=5, reg_wdata=7, pc_out=0x8000_0004.
- Taken branch: branch=1, exu_result=1, zero_flag=0, imm=-8 (0xFFFF_FFF8), pc=0x8000_0010 -> pc_out=0x8000_0008, reg_wen=0. Same with zero_flag=1 -> pc_out=0x8000_0014.
- jalr: src1=0x8000_0101, imm=4, exu_result=pc+4 -> pc_out=0x8000_0104, reg_wdata=pc+4.
- LB at exu_result=0x8000_0003, mem_rdata=0x80xx_xxxx after 2 wait cycles -> mem_addr=0x8000_0000, reg_wdata=0xFFFF_FF80. LBU at the same address -> reg_wdata=0x0000_0080.
- rd=0, rd_wen=1, exu_result=0x1234 -> commit=1, reg_wen=0.
- Deassert rst_n during MEM_WAIT, then pulse mem_rvalid -> no commit, no reg_wen, state IDLE, pc_out=RESET_PC. With the macro defined: LW at 0x8000_0002 -> no mem_req, exc_valid=1, commit=0.
